bcd_serial_subtractor: RTL and testbench
========================================

BCD_SERIAL_SUBTRACTOR -- requirements
Module: bcd_serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: DIGITS, default 4, the number of packed BCD digits per operand (legal range 2..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request strobe, sampled on clk rising edges.
REQ-005 The block SHALL have port a, input, 4*DIGITS bits: minuend, packed BCD, digit 0 in a[3:0].
REQ-006 The block SHALL have port b, input, 4*DIGITS bits: subtrahend, same packing as a.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-009 The block SHALL have port diff, output, 4*DIGITS bits: magnitude |A-B|, packed BCD.
REQ-010 The block SHALL have port neg, output, 1 bit: high when A<B.
REQ-011 The block SHALL have port err, output, 1 bit: high when the captured operands held a non-BCD digit.

Function
REQ-012 The FSM SHALL have the states IDLE, CHECK, SUB, FIX and DONE; busy SHALL be high in every state except IDLE.
REQ-013 In IDLE, start=1 SHALL capture a and b into internal registers and move the FSM to CHECK; start SHALL be ignored in every other state.
REQ-014 In CHECK, any captured digit greater than 9 SHALL set err=1, diff=0 and neg=0, and SHALL move the FSM to DONE.
REQ-015 In CHECK with all digits valid, the block SHALL clear err, set the digit index to 0 and the carry to 1, and move the FSM to SUB.
REQ-016 SUB SHALL process one digit per cycle, least significant first, as sum = a_i + (9 - b_i) + carry; sums of 10 or more SHALL be corrected by subtracting 10, with carry out set to 1.
REQ-017 After digit DIGITS-1, a final carry of 1 SHALL give neg=0 with the result held as diff, and the FSM SHALL move to DONE.
REQ-018 After digit DIGITS-1, a final carry of 0 SHALL set neg=1 and move the FSM to FIX.
REQ-019 FIX SHALL replace the result with its 10's complement, one digit per cycle, least significant first, starting with carry 1, with digit = (9 - r_i) + carry corrected as in REQ-016; the FSM SHALL then move to DONE.
REQ-020 DONE SHALL assert done for exactly one cycle and return to IDLE; a start in the DONE cycle SHALL be ignored.
REQ-021 Latency, counted in edges from the edge that samples start to the edge that raises done, SHALL be 2 for an error, DIGITS+2 for A>=B and 2*DIGITS+2 for A<B.
REQ-022 diff, neg and err SHALL change only in CHECK, SUB, FIX or DONE, and SHALL hold their values from done until the next accepted start.
REQ-023 The result of A==B SHALL be diff=0 with neg=0; negative zero SHALL never be produced.
REQ-024 Changes on a and b after capture SHALL NOT affect the operation in progress.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for a clock edge, force the FSM to IDLE and drive busy=0, done=0, diff=0, neg=0 and err=0, including in the middle of an operation.
REQ-026 After rst_n is released, the first rising edge of clk with start=1 SHALL be accepted normally.

Verification (DIGITS=4)
REQ-027 a=5321, b=1234, start pulse -> done 6 edges later with diff=4087, neg=0, err=0, and busy high throughout.
REQ-028 a=1234, b=5321 -> done 10 edges later with diff=4087 and neg=1.
REQ-029 a=0000, b=9999 -> diff=9999 and neg=1; a=7777, b=7777 -> diff=0000 and neg=0; a=9999, b=0000 -> diff=9999 and neg=0.
REQ-030 a=12A4, b=0001 -> done 2 edges later with err=1, diff=0 and neg=0; a following valid operation SHALL clear err.
REQ-031 A second start, with different a and b, applied during SUB and again during DONE -> ignored; the result SHALL match the first operands only.
REQ-032 rst_n pulsed low in the middle of FIX -> all outputs 0 at once, no done pulse; a new start after release SHALL produce a correct result.

Source files
------------

// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor: digit-serial packed-BCD subtractor producing |A-B| with sign and invalid-digit flag
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  neg,
  output logic                  err
);
  localparam int W = 4 * DIGITS;
  typedef enum logic [2:0] {IDLE, CHECK, SUB, FIX, DONE} state_t;
  state_t       state_q;
  logic [W-1:0] a_q, b_q, diff_q;
  logic [3:0]   idx_q;
  logic         carry_q, neg_q, err_q, done_q;
  logic         bad_d, cout_d, last_d;
  logic [4:0]   sum_d;
  logic [3:0]   dig_d;
  // Digit validity scan and the shared nines-complement digit adder; operands and result are
  // shifted right each step so only the low nibble is ever examined.
  always_comb begin
    bad_d = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad_d = bad_d | (a_q[4*i +: 4] > 4'd9) | (b_q[4*i +: 4] > 4'd9);
    sum_d = (state_q == FIX) ? 5'(4'd9 - diff_q[3:0]) + 5'(carry_q)
                             : 5'(a_q[3:0]) + 5'(4'd9 - b_q[3:0]) + 5'(carry_q);
    cout_d = sum_d >= 5'd10;
    dig_d  = cout_d ? 4'(sum_d - 5'd10) : sum_d[3:0];
    last_d = idx_q == 4'(DIGITS - 1);
  end
  // Control FSM with registered outputs; done is raised on the edge that leaves DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          a_q     <= a;
          b_q     <= b;
          state_q <= CHECK;
        end
        CHECK: begin
          neg_q <= 1'b0;
          if (bad_d) begin
            err_q   <= 1'b1;
            diff_q  <= '0;
            state_q <= DONE;
          end else begin
            err_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b1;
            state_q <= SUB;
          end
        end
        SUB: begin
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          diff_q  <= {dig_d, diff_q[W-1:4]};
          carry_q <= cout_d;
          idx_q   <= idx_q + 4'd1;
          if (last_d) begin
            idx_q   <= '0;
            carry_q <= 1'b1;
            neg_q   <= !cout_d;
            state_q <= cout_d ? DONE : FIX;
          end
        end
        FIX: begin
          diff_q  <= {dig_d, diff_q[W-1:4]};
          carry_q <= cout_d;
          idx_q   <= idx_q + 4'd1;
          if (last_d) state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign diff = diff_q;
  assign neg  = neg_q;
  assign err  = err_q;
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// tb_bcd_serial_subtractor: vector table, random ops against an integer model, and corner sequences
module tb_bcd_serial_subtractor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, neg, err;
  logic [15:0] diff;
  int          checks = 0, errors = 0;

  bcd_serial_subtractor #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b, d;
    logic        n, e;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int x);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic bad(input logic [15:0] v);
    logic r = 1'b0;
    for (int i = 0; i < 4; i++) r = r | (v[4*i +: 4] > 4'd9);
    return r;
  endfunction

  function automatic vec_t model(input logic [15:0] x, input logic [15:0] y);
    vec_t v;
    int ia, ib;
    v.a = x;
    v.b = y;
    v.e = bad(x) | bad(y);
    ia = bcd2int(x);
    ib = bcd2int(y);
    v.n = !v.e && ia < ib;
    v.d = v.e ? 16'h0 : int2bcd(v.n ? ib - ia : ia - ib);
    v.lat = v.e ? 2 : (v.n ? 10 : 6);
    return v;
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    int lat = 0, gaps = 0;
    @(negedge clk);
    a = v.a;
    b = v.b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    for (int i = 1; i <= 60; i++) begin
      if (!busy) gaps++;
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_lat"}, lat, v.lat);
    chk({tag, "_busy_gap"}, gaps, 0);
    chk({tag, "_diff"}, diff, v.d);
    chk({tag, "_neg"}, neg, v.n);
    chk({tag, "_err"}, err, v.e);
  endtask

  vec_t tbl[8];
  vec_t rv;
  logic [15:0] ra, rb;

  initial begin
    tbl[0] = '{16'h5321, 16'h1234, 16'h4087, 1'b0, 1'b0, 6};
    tbl[1] = '{16'h1234, 16'h5321, 16'h4087, 1'b1, 1'b0, 10};
    tbl[2] = '{16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 10};
    tbl[3] = '{16'h7777, 16'h7777, 16'h0000, 1'b0, 1'b0, 6};
    tbl[4] = '{16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 6};
    tbl[5] = '{16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 2};
    tbl[6] = '{16'h0001, 16'h0002, 16'h0001, 1'b1, 1'b0, 10};
    tbl[7] = '{16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 6};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_neg", neg, 0);
    chk("rst_err", err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 4; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) rb[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      if (k % 10 == 0) rb = ra;
      rv = model(ra, rb);
      run_op(rv, $sformatf("rnd%0d", k));
    end

    // second start during SUB and during the DONE cycle must be ignored
    @(negedge clk);
    a = 16'h5321;
    b = 16'h1234;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 16'h0011;
    b = 16'h9000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a = 16'h0003;
    b = 16'h0888;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("ign_done", done, 1);
    chk("ign_diff", diff, 16'h4087);
    chk("ign_neg", neg, 0);
    @(posedge clk);
    #1;
    chk("ign_busy_after", busy, 0);
    chk("ign_done_after", done, 0);

    // asynchronous reset in the middle of FIX
    @(negedge clk);
    a = 16'h1234;
    b = 16'h5321;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_neg", neg, 0);
    chk("mid_rst_err", err, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_no_done", done, 0);
    chk("mid_rst_idle", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    run_op(tbl[0], "post_rst");
    run_op(tbl[1], "post_rst_neg");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
